// File: rtl/fhc_pkg.sv
// rtl/fhc_pkg.sv - opcode, FSM state and destination-decode helpers for fwd_hazard_ctrl
package fhc_pkg;

    localparam int FHC_IW = 16;
    localparam int FHC_RW = 3;

    localparam logic [3:0] OP_ADI  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LLI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_LM   = 4'b0110;
    localparam logic [3:0] OP_SM   = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_JAL  = 4'b1100;
    localparam logic [3:0] OP_JLR  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LU   = 2'd1,
        SEQ  = 2'd2
    } fhc_state_e;

    // Architectural destination register of an instruction (0 when it has none).
    function automatic logic [FHC_RW-1:0] dest_of(input logic [FHC_IW-1:0] ir);
        case (ir[15:12])
            OP_ADD, OP_NAND:              dest_of = ir[5:3];
            OP_ADI:                       dest_of = ir[8:6];
            OP_LLI, OP_LW, OP_JAL, OP_JLR: dest_of = ir[11:9];
            default:                      dest_of = '0;
        endcase
    endfunction

    // Whether the instruction actually writes its destination, given the
    // flags visible to its stage. ADD/NAND with cond 10 need carry, 01 need zero.
    function automatic logic writes_of(input logic [FHC_IW-1:0] ir,
                                       input logic cf, input logic zf);
        case (ir[15:12])
            OP_ADD, OP_NAND: begin
                case (ir[1:0])
                    2'b10:   writes_of = cf;
                    2'b01:   writes_of = zf;
                    default: writes_of = 1'b1;
                endcase
            end
            OP_ADI, OP_LLI, OP_LW, OP_JAL, OP_JLR: writes_of = 1'b1;
            default:                               writes_of = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_dec.sv
// rtl/fwd_hazard_ctrl_dec.sv - per-stage destination / write-enable decoder
// Ports: ir (stage IR), vld (stage valid), cf/zf (flags seen by the stage),
//        dest (destination register), we (stage will write dest).
module ir_dest_decode
    import fhc_pkg::*;
(
    input  logic [FHC_IW-1:0] ir,
    input  logic              vld,
    input  logic              cf,
    input  logic              zf,
    output logic [FHC_RW-1:0] dest,
    output logic              we
);

    assign dest = dest_of(ir);
    assign we   = vld && writes_of(ir, cf, zf);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - operand forwarding, load-use stall and LM/SM walk controller
// Ports: clk/rst (async active-high); id_rr_ir/id_rr_vld (consumer in ID_RR);
//        stg_ir/stg_vld/stg_cf/stg_zf (downstream stages, slice k-1 = stage k);
//        fwd_a_sel/fwd_b_sel (registered, 0=RF, k=stage k); stall/bubble;
//        seq_active/seq_reg/seq_off/seq_last (LM/SM register walk).
module fwd_hazard_ctrl
    import fhc_pkg::*;
#(
    parameter int IW       = 16,
    parameter int RW       = 3,
    parameter int NSTAGE   = 3,
    parameter int NREG     = 8,
    parameter int LU_STALL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IW-1:0]               id_rr_ir,
    input  logic                        id_rr_vld,
    input  logic [NSTAGE*IW-1:0]        stg_ir,
    input  logic [NSTAGE-1:0]           stg_vld,
    input  logic [NSTAGE-1:0]           stg_cf,
    input  logic [NSTAGE-1:0]           stg_zf,
    output logic [$clog2(NSTAGE+1)-1:0] fwd_a_sel,
    output logic [$clog2(NSTAGE+1)-1:0] fwd_b_sel,
    output logic                        stall,
    output logic                        bubble,
    output logic                        seq_active,
    output logic [RW-1:0]               seq_reg,
    output logic [RW:0]                 seq_off,
    output logic                        seq_last
);

    localparam int SW = $clog2(NSTAGE + 1);
    localparam int OW = RW + 1;

    logic [3:0]      id_op;
    logic [RW-1:0]   src_a;
    logic [RW-1:0]   src_b;
    logic            use_a;
    logic            use_b;

    assign id_op = id_rr_ir[IW-1:IW-4];
    assign src_a = id_rr_ir[11:9];
    assign src_b = id_rr_ir[8:6];

    // An invalid ID_RR slot reads nothing, so it can neither match nor stall.
    always_comb begin
        use_a = id_rr_vld && (id_op inside {OP_ADD, OP_NAND, OP_ADI, OP_SW, OP_BEQ});
        use_b = id_rr_vld && (id_op inside {OP_ADD, OP_NAND, OP_LW, OP_SW, OP_BEQ, OP_JLR});
    end

    logic [RW-1:0]     st_dest [NSTAGE];
    logic [NSTAGE-1:0] st_we;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_dec
        ir_dest_decode u_dec (
            .ir   (stg_ir[k*IW +: IW]),
            .vld  (stg_vld[k]),
            .cf   (stg_cf[k]),
            .zf   (stg_zf[k]),
            .dest (st_dest[k]),
            .we   (st_we[k])
        );
    end

    // Scan from the farthest stage down so the nearest producer overwrites.
    logic [SW-1:0] a_nxt;
    logic [SW-1:0] b_nxt;

    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (use_a && st_we[k] && (st_dest[k] == src_a)) a_nxt = SW'(k + 1);
            if (use_b && st_we[k] && (st_dest[k] == src_b)) b_nxt = SW'(k + 1);
        end
    end

    // Load-use: the value from a load in RR_EX is not available to forward in time.
    logic [3:0]      s1_op;
    logic [NREG-1:0] s1_mask;
    logic            lu_hit;

    assign s1_op   = stg_ir[IW-1:IW-4];
    assign s1_mask = stg_ir[NREG-1:0];

    always_comb begin
        lu_hit = 1'b0;
        if (st_we[0] && (s1_op == OP_LW) &&
            ((use_a && (st_dest[0] == src_a)) || (use_b && (st_dest[0] == src_b))))
            lu_hit = 1'b1;
        if (stg_vld[0] && (s1_op == OP_LM) &&
            ((use_a && s1_mask[src_a]) || (use_b && s1_mask[src_b])))
            lu_hit = 1'b1;
    end

    logic            seq_trig;
    logic [NREG-1:0] id_mask;

    assign seq_trig = id_rr_vld && ((id_op == OP_LM) || (id_op == OP_SM));
    assign id_mask  = id_rr_ir[NREG-1:0];

    fhc_state_e      state;
    logic [NREG-1:0] mask_q;
    logic [RW:0]     off_q;
    logic [1:0]      lu_cnt;

    logic [RW-1:0]   lsb_idx;
    logic            single;
    logic [NREG-1:0] mask_nxt;

    always_comb begin
        lsb_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_q[i]) lsb_idx = RW'(i);
        end
    end

    // Exactly one bit left means this transfer ends the walk.
    assign single   = ((mask_q & (mask_q - NREG'(1))) == '0);
    assign mask_nxt = mask_q & ~(NREG'(1) << lsb_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask_q    <= '0;
            off_q     <= '0;
            lu_cnt    <= '0;
            fwd_a_sel <= '0;
            fwd_b_sel <= '0;
        end else begin
            fwd_a_sel <= a_nxt;
            fwd_b_sel <= b_nxt;
            case (state)
                IDLE: begin
                    if (lu_hit) begin
                        state  <= LU;
                        lu_cnt <= 2'(LU_STALL - 1);
                    end else if (seq_trig && (id_mask != '0)) begin
                        state  <= SEQ;
                        mask_q <= id_mask;
                        off_q  <= '0;
                    end
                end
                LU: begin
                    if (lu_cnt == 2'd0) state <= IDLE;
                    else                lu_cnt <= lu_cnt - 2'd1;
                end
                SEQ: begin
                    mask_q <= mask_nxt;
                    off_q  <= off_q + OW'(1);
                    if (single) begin
                        state <= IDLE;
                        off_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign seq_active = (state == SEQ);
    assign bubble     = (state == LU);
    assign stall      = (state == LU) || (seq_active && !single);
    assign seq_reg    = seq_active ? lsb_idx : '0;
    assign seq_off    = seq_active ? off_q : '0;
    assign seq_last   = seq_active && single;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - scoreboard bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    localparam int IW = 16;
    localparam int RW = 3;
    localparam int NSTAGE = 3;
    localparam int NREG = 8;
    localparam int LU_STALL = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [IW-1:0]        id_rr_ir;
    logic                 id_rr_vld;
    logic [NSTAGE*IW-1:0] stg_ir;
    logic [NSTAGE-1:0]    stg_vld, stg_cf, stg_zf;
    logic [1:0]           fwd_a_sel, fwd_b_sel;
    logic                 stall, bubble, seq_active, seq_last;
    logic [RW-1:0]        seq_reg;
    logic [RW:0]          seq_off;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       fsm;
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic       bu;
        logic       act;
        logic [2:0] rg;
        logic [3:0] off;
        logic       last;
    } exp_t;

    exp_t sb[$];

    fwd_hazard_ctrl #(
        .IW(IW), .RW(RW), .NSTAGE(NSTAGE), .NREG(NREG), .LU_STALL(LU_STALL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_rr_ir   (id_rr_ir),
        .id_rr_vld  (id_rr_vld),
        .stg_ir     (stg_ir),
        .stg_vld    (stg_vld),
        .stg_cf     (stg_cf),
        .stg_zf     (stg_zf),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .bubble     (bubble),
        .seq_active (seq_active),
        .seq_reg    (seq_reg),
        .seq_off    (seq_off),
        .seq_last   (seq_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_fsm(input logic [1:0] a, input logic [1:0] b, input logic st,
                           input logic bu, input logic act, input logic [2:0] rg,
                           input logic [3:0] off, input logic last);
        exp_t e;
        e = '{fsm: 1'b1, a: a, b: b, st: st, bu: bu, act: act, rg: rg, off: off, last: last};
        sb.push_back(e);
    endtask

    task automatic exp_fwd(input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        e = '{fsm: 1'b0, a: a, b: b, st: 1'b0, bu: 1'b0, act: 1'b0, rg: 3'd0, off: 4'd0, last: 1'b0};
        sb.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".fwd_a"}, 32'(fwd_a_sel), 32'(e.a));
            check({tag, ".fwd_b"}, 32'(fwd_b_sel), 32'(e.b));
            if (e.fsm) begin
                check({tag, ".stall"}, 32'(stall), 32'(e.st));
                check({tag, ".bubble"}, 32'(bubble), 32'(e.bu));
                check({tag, ".seq_active"}, 32'(seq_active), 32'(e.act));
                check({tag, ".seq_reg"}, 32'(seq_reg), 32'(e.rg));
                check({tag, ".seq_off"}, 32'(seq_off), 32'(e.off));
                check({tag, ".seq_last"}, 32'(seq_last), 32'(e.last));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".fwd_a"}, 32'(fwd_a_sel), 32'd0);
        check({tag, ".fwd_b"}, 32'(fwd_b_sel), 32'd0);
        check({tag, ".stall"}, 32'(stall), 32'd0);
        check({tag, ".bubble"}, 32'(bubble), 32'd0);
        check({tag, ".seq_active"}, 32'(seq_active), 32'd0);
        check({tag, ".seq_reg"}, 32'(seq_reg), 32'd0);
        check({tag, ".seq_off"}, 32'(seq_off), 32'd0);
        check({tag, ".seq_last"}, 32'(seq_last), 32'd0);
    endtask

    task automatic idle_in();
        id_rr_ir  = '0;
        id_rr_vld = 1'b0;
        stg_ir    = '0;
        stg_vld   = '0;
        stg_cf    = '0;
        stg_zf    = '0;
    endtask

    task automatic set_stg(input int k, input logic [15:0] ir, input logic v,
                           input logic cf, input logic zf);
        stg_ir[k*16 +: 16] = ir;
        stg_vld[k] = v;
        stg_cf[k]  = cf;
        stg_zf[k]  = zf;
    endtask

    // Reference decode written from the ISA description.
    function automatic bit m_dest(input logic [15:0] ir, input logic cf, input logic zf,
                                  output logic [2:0] d);
        d = 3'd0;
        case (ir[15:12])
            4'd1, 4'd2: begin
                d = ir[5:3];
                if (ir[1:0] == 2'b10) return cf;
                if (ir[1:0] == 2'b01) return zf;
                return 1'b1;
            end
            4'd0: begin
                d = ir[8:6];
                return 1'b1;
            end
            4'd3, 4'd4, 4'd12, 4'd13: begin
                d = ir[11:9];
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_sel(input bit is_b);
        logic [3:0] op;
        logic [2:0] src;
        logic [2:0] d;
        bit uses;
        bit w;
        op = id_rr_ir[15:12];
        if (is_b) begin
            src  = id_rr_ir[8:6];
            uses = op inside {4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd13};
        end else begin
            src  = id_rr_ir[11:9];
            uses = op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd8};
        end
        if (!id_rr_vld || !uses) return 2'd0;
        for (int k = 0; k < 3; k++) begin
            w = m_dest(stg_ir[k*16 +: 16], stg_cf[k], stg_zf[k], d);
            if (stg_vld[k] && w && (d == src)) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    initial begin
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // forward A from stage 1
        set_stg(0, 16'h1298, 1'b1, 1'b0, 1'b0);
        id_rr_ir = 16'h1728; id_rr_vld = 1'b1;
        exp_fsm(2'd1, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("fwd_a_ex");

        // nearest producer wins, then stage 3 alone
        idle_in();
        set_stg(0, 16'h1298, 1'b1, 1'b0, 1'b0);
        set_stg(2, 16'h1298, 1'b1, 1'b0, 1'b0);
        id_rr_ir = 16'h10F0; id_rr_vld = 1'b1;
        exp_fsm(2'd0, 2'd1, 0, 0, 0, 3'd0, 4'd0, 0);
        step("prio_b");
        set_stg(0, 16'h0000, 1'b0, 1'b0, 1'b0);
        exp_fwd(2'd0, 2'd3);
        step("stage3_only");

        // conditional writes in stage 2
        idle_in();
        set_stg(1, 16'h129A, 1'b1, 1'b0, 1'b0);
        id_rr_ir = 16'h1728; id_rr_vld = 1'b1;
        exp_fwd(2'd0, 2'd0); step("adc_cf0");
        stg_cf[1] = 1'b1;
        exp_fwd(2'd2, 2'd0); step("adc_cf1");
        set_stg(1, 16'h1299, 1'b1, 1'b1, 1'b0);
        exp_fwd(2'd0, 2'd0); step("adz_zf0");
        stg_zf[1] = 1'b1;
        exp_fwd(2'd2, 2'd0); step("adz_zf1");
        id_rr_vld = 1'b0;
        exp_fwd(2'd0, 2'd0); step("id_invalid");
        id_rr_vld = 1'b1; stg_vld[1] = 1'b0;
        exp_fwd(2'd0, 2'd0); step("stg_invalid");

        // load-use on LW
        idle_in();
        set_stg(0, 16'h4600, 1'b1, 1'b0, 1'b0);
        id_rr_ir = 16'h1728; id_rr_vld = 1'b0;
        exp_fsm(2'd0, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("lu_suppressed");
        id_rr_vld = 1'b1;
        exp_fsm(2'd1, 2'd0, 1, 1, 0, 3'd0, 4'd0, 0);
        step("lu_enter");
        set_stg(0, 16'h0000, 1'b0, 1'b0, 1'b0);
        set_stg(1, 16'h4600, 1'b1, 1'b0, 1'b0);
        exp_fsm(2'd2, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("lu_exit");
        exp_fsm(2'd2, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("lu_after");

        // load-use on LM whose mask covers operand B
        idle_in();
        set_stg(0, 16'h6010, 1'b1, 1'b0, 1'b0);
        id_rr_ir = 16'h1728; id_rr_vld = 1'b1;
        exp_fsm(2'd0, 2'd0, 1, 1, 0, 3'd0, 4'd0, 0);
        step("lm_lu");
        idle_in();
        exp_fsm(2'd0, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("lm_lu_exit");

        // LM walk, mask 0x92
        id_rr_ir = 16'h6092; id_rr_vld = 1'b1;
        exp_fsm(2'd0, 2'd0, 1, 0, 1, 3'd1, 4'd0, 0);
        step("lm_t0");
        id_rr_vld = 1'b0;
        exp_fsm(2'd0, 2'd0, 1, 0, 1, 3'd4, 4'd1, 0);
        step("lm_t1");
        exp_fsm(2'd0, 2'd0, 0, 0, 1, 3'd7, 4'd2, 1);
        step("lm_t2");
        exp_fsm(2'd0, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("lm_done");

        // empty mask never starts a walk
        id_rr_ir = 16'h6000; id_rr_vld = 1'b1;
        exp_fsm(2'd0, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("lm_mask0");
        id_rr_vld = 1'b0;
        exp_fsm(2'd0, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("lm_mask0_b");

        // reset in the middle of an SM walk, then restart from bit 0
        id_rr_ir = 16'h70FF; id_rr_vld = 1'b1;
        exp_fsm(2'd0, 2'd0, 1, 0, 1, 3'd0, 4'd0, 0);
        step("sm_t0");
        id_rr_vld = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("mid_walk_rst");
        @(negedge clk);
        rst = 1'b0;
        id_rr_ir = 16'h6003; id_rr_vld = 1'b1;
        exp_fsm(2'd0, 2'd0, 1, 0, 1, 3'd0, 4'd0, 0);
        step("restart_t0");
        id_rr_vld = 1'b0;
        exp_fsm(2'd0, 2'd0, 0, 0, 1, 3'd1, 4'd1, 1);
        step("restart_t1");
        exp_fsm(2'd0, 2'd0, 0, 0, 0, 3'd0, 4'd0, 0);
        step("restart_done");

        // random forwarding against the reference decode
        for (int n = 0; n < 300; n++) begin
            stg_ir    = {$urandom, $urandom};
            stg_vld   = 3'($urandom);
            stg_cf    = 3'($urandom);
            stg_zf    = 3'($urandom);
            id_rr_ir  = 16'($urandom);
            id_rr_vld = ($urandom_range(0, 3) != 0);
            exp_fwd(m_sel(1'b0), m_sel(1'b1));
            step("rand");
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
